// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core's MEM stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
    logic        dreq;
    logic        dwrite;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] input_ddata;
    logic [31:0] output_ddata;
    logic        dready_n;
    logic        dbusy;
    logic        derr;

    // Handshake: the master holds dreq and every request field stable until it
    // samples dready_n low; dready_n is low for exactly one cycle per request,
    // and derr/output_ddata are meaningful in that cycle.
    modport master (
        output dreq, dwrite, dsize, daddr, input_ddata,
        input  output_ddata, dready_n, dbusy, derr
    );

    modport slave (
        input  dreq, dwrite, dsize, daddr, input_ddata,
        output output_ddata, dready_n, dbusy, derr
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised little-endian RAM with byte-lane
// steering, programmable wait states and a one-cycle active-low completion strobe.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state
);
    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          req_err;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [31:0]   load_val;

    // Request decode works only on the captured copy of the request.
    always_comb begin
        off  = addr_q - BASE_ADDR;
        idx  = off[AW+1:2];
        lane = off[1:0];

        req_err = 1'b0;
        case (size_q)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = lane[0];
            2'b10:   req_err = |lane;
            default: req_err = 1'b1;
        endcase
        // Anything below BASE_ADDR wraps to a large offset and lands here too.
        if (off[31:AW+2] != '0) begin
            req_err = 1'b1;
        end

        case (size_q)
            2'b00: begin
                mem_be    = 4'b0001 << lane;
                mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = wdata_q;
            end
        endcase

        mem_we  = (state_q == S_ACCESS) && wr_q && !req_err;
        rd_word = mem[idx];

        case (size_q)
            2'b00:   load_val = {24'b0, rd_word[{lane, 3'b000} +: 8]};
            2'b01:   load_val = {16'b0, rd_word[{lane[1], 4'b0000} +: 16]};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.dreq) begin
                    wr_d    = bus.dwrite;
                    size_d  = bus.dsize;
                    addr_d  = bus.daddr;
                    wdata_d = bus.input_ddata;
                    cnt_d   = LAT;
                    state_d = (LAT != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                // Stores leave the read register alone; errored loads clear it.
                if (!wr_q) begin
                    rdata_d = req_err ? 32'h0 : load_val;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.dready_n     = (state_q != S_RESP);
        bus.dbusy        = (state_q == S_WAIT) || (state_q == S_ACCESS);
        bus.derr         = (state_q == S_RESP) && req_err;
        bus.output_ddata = rdata_q;
        dbg_state        = state_q;
    end
endmodule
